// File: rtl/serial_in.sv
// serial_in: variable-rate serial receiver, LSB first, one/repeat framing.
// Optional SERIAL_IN_MAJORITY_EN: 3-sample majority vote around each sample.
module serial_in #(
  parameter int DATA_BIT    = 32,
  parameter int LOW_FREQ    = 9,
  parameter int HIGH_FREQ   = 3,
  parameter int START_DELAY = 2,
  parameter int GAP         = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_serial_in,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_bit_tick,
  output logic                o_done_tick,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_e;

`ifdef SERIAL_IN_MAJORITY_EN
  // vote completes one edge after the centre sample
  localparam int MAJ_OFS = 1;
`else
  localparam int MAJ_OFS = 0;
`endif

  localparam logic [7:0] HI_N = 8'(HIGH_FREQ);
  localparam logic [7:0] LO_N = 8'(LOW_FREQ);
  localparam logic [7:0] HI_CAP =
    8'(HIGH_FREQ - 1 - (HIGH_FREQ - 1) / 2 - MAJ_OFS);
  localparam logic [7:0] LO_CAP =
    8'(LOW_FREQ - 1 - (LOW_FREQ - 1) / 2 - MAJ_OFS);
  localparam logic [7:0] SD_LOAD =
    8'(START_DELAY >= 2 ? START_DELAY - 2 : 0);
  localparam logic [7:0] GAP_LOAD =
    8'(GAP >= 1 ? GAP - 1 : 0);
  localparam logic [5:0] LAST = 6'(DATA_BIT - 1);

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [5:0]          idx_q;
  logic [DATA_BIT-1:0] freq_q;
  logic [DATA_BIT-1:0] shreg_q;
  logic                bit_q;
  logic [1:0]          hist_q;
  logic [DATA_BIT-1:0] data_q;
  logic                bit_tick_q;
  logic                done_tick_q;
  logic                busy_q;

  logic                cur_f;
  logic                nxt_f;
  logic [7:0]          cap;
  logic                samp;
  logic                bit_now;
  logic [DATA_BIT-1:0] word_d;
  logic [7:0]          first_n;
  logic [7:0]          next_n;
  logic [7:0]          frame0_n;

  // current/next bit rate, sample value and the word with bit k merged
  always_comb begin
    cur_f = 1'b0;
    nxt_f = freq_q[0];
    for (int i = 0; i < DATA_BIT; i++) begin
      if (idx_q == 6'(i)) cur_f = freq_q[i];
    end
    for (int i = 1; i < DATA_BIT; i++) begin
      if (idx_q == 6'(i - 1)) nxt_f = freq_q[i];
    end
    cap = cur_f ? HI_CAP : LO_CAP;
`ifdef SERIAL_IN_MAJORITY_EN
    samp = (hist_q[1] & hist_q[0]) |
           (hist_q[1] & i_serial_in) |
           (hist_q[0] & i_serial_in);
`else
    samp = i_serial_in;
`endif
    bit_now = (cnt_q == cap) ? samp : bit_q;
    word_d = shreg_q;
    for (int i = 0; i < DATA_BIT; i++) begin
      if (idx_q == 6'(i)) word_d[i] = bit_now;
    end
    first_n  = i_freq_pattern[0] ? HI_N : LO_N;
    next_n   = nxt_f ? HI_N : LO_N;
    frame0_n = freq_q[0] ? HI_N : LO_N;
  end

  // receive FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      freq_q      <= '0;
      shreg_q     <= '0;
      bit_q       <= 1'b0;
      hist_q      <= '0;
      data_q      <= '0;
      bit_tick_q  <= 1'b0;
      done_tick_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_tick_q  <= 1'b0;
      done_tick_q <= 1'b0;
      hist_q      <= {hist_q[0], i_serial_in};
      if (i_stop && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (i_start) begin
        freq_q  <= i_freq_pattern;
        shreg_q <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b1;
        if (START_DELAY == 1) begin
          state_q <= S_RECV;
          cnt_q   <= first_n - 8'd1;
        end else begin
          state_q <= S_WAIT;
          cnt_q   <= SD_LOAD;
        end
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_WAIT, S_GAP: begin
            if (cnt_q == 8'd0) begin
              state_q <= S_RECV;
              cnt_q   <= frame0_n - 8'd1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_RECV: begin
            if (cnt_q == cap) bit_q <= samp;
            if (cnt_q != 8'd0) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              shreg_q    <= word_d;
              bit_tick_q <= 1'b1;
              if (idx_q == LAST) begin
                data_q      <= word_d;
                done_tick_q <= 1'b1;
                idx_q       <= '0;
                shreg_q     <= '0;
                if (i_mode) begin
                  if (GAP == 0) begin
                    state_q <= S_RECV;
                    cnt_q   <= frame0_n - 8'd1;
                  end else begin
                    state_q <= S_GAP;
                    cnt_q   <= GAP_LOAD;
                  end
                end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                idx_q <= idx_q + 6'd1;
                cnt_q <= next_n - 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_data      = data_q;
  assign o_bit_tick  = bit_tick_q;
  assign o_done_tick = done_tick_q;
  assign o_busy      = busy_q;

endmodule
